vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen_if.sv | 29 ++
 rtl/vga_pattern_gen.sv | 156 +++++++++++++++
 tb/tb_vga_pattern_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// ============================================================================
// Module      : vga_pattern_gen_if
// Description : Pattern select input and VGA pixel/sync bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_pattern_gen_if;
    logic       pattern_sel;
    logic [7:0] pixel;
    logic       hsync;
    logic       vsync;

    modport master (
        input  pattern_sel,
        output pixel,
        output hsync,
        output vsync
    );

    modport slave (
        output pattern_sel,
        input  pixel,
        input  hsync,
        input  vsync
    );
endinterface

`default_nettype wire

// File: rtl/vga_pattern_gen.sv
// ============================================================================
// Module      : vga_pattern_gen
// Description : Free-running VGA timing generator with colour-bar / XOR test
//               patterns. Define VGA_FRAME_ANIM_EN to animate per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pattern_gen #(
    parameter int H_VISIBLE = 720,
    parameter int H_FP      = 36,
    parameter int H_SYNC    = 72,
    parameter int H_BP      = 108,
    parameter int V_VISIBLE = 400,
    parameter int V_FP      = 2,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 5
) (
    input  wire                 clk,
    input  wire                 rst_n,
    vga_pattern_gen_if.master   vga
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    // Counters are at least 8 bits so the XOR pattern can always take [7:0]
    localparam int HW = ($clog2(c_H_TOTAL) > 8) ? $clog2(c_H_TOTAL) : 8;
    localparam int VW = ($clog2(c_V_TOTAL) > 8) ? $clog2(c_V_TOTAL) : 8;
    localparam int c_BAR_W = H_VISIBLE / 8;
    localparam int BW = ($clog2(c_BAR_W) > 0) ? $clog2(c_BAR_W) : 1;

    localparam logic [HW-1:0] c_H_LAST  = HW'(c_H_TOTAL - 1);
    localparam logic [HW-1:0] c_H_VIS   = HW'(H_VISIBLE);
    localparam logic [HW-1:0] c_HS_BEG  = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] c_HS_END  = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] c_V_LAST  = VW'(c_V_TOTAL - 1);
    localparam logic [VW-1:0] c_V_VIS   = VW'(V_VISIBLE);
    localparam logic [VW-1:0] c_VS_BEG  = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] c_VS_END  = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [BW-1:0] c_BAR_END = BW'(c_BAR_W - 1);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [BW-1:0] r_bar_px;
    logic [2:0]    r_bar;
    logic [7:0]    r_pixel;
    logic          r_hsync;
    logic          r_vsync;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_active;
    logic          w_hsync;
    logic          w_vsync;
    logic [2:0]    w_bar_idx;
    logic [7:0]    w_xor_v;
    logic [7:0]    w_pixel;

    function automatic logic [7:0] f_bar_colour(input logic [2:0] i_idx);
        logic [7:0] v_c;
        case (i_idx)
            3'd0:    v_c = 8'hFF;
            3'd1:    v_c = 8'hFC;
            3'd2:    v_c = 8'h1F;
            3'd3:    v_c = 8'h1C;
            3'd4:    v_c = 8'hE3;
            3'd5:    v_c = 8'hE0;
            3'd6:    v_c = 8'h03;
            default: v_c = 8'h00;
        endcase
        return v_c;
    endfunction

    assign w_h_last = (r_hcnt == c_H_LAST);
    assign w_v_last = (r_vcnt == c_V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    // Bar index tracked incrementally alongside hcnt, avoiding a divide-by-90
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (w_h_last) begin
            r_bar_px <= '0;
            r_bar    <= '0;
        end else if (r_bar_px == c_BAR_END) begin
            r_bar_px <= '0;
            r_bar    <= r_bar + 3'd1;
        end else begin
            r_bar_px <= r_bar_px + 1'b1;
        end
    end

`ifdef VGA_FRAME_ANIM_EN
    logic [7:0] r_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= '0;
        end else if (w_h_last && w_v_last) begin
            r_frame <= r_frame + 8'd1;
        end
    end

    assign w_bar_idx = r_bar - r_frame[2:0];
    assign w_xor_v   = r_vcnt[7:0] + r_frame;
`else
    assign w_bar_idx = r_bar;
    assign w_xor_v   = r_vcnt[7:0];
`endif

    assign w_active = (r_hcnt < c_H_VIS) && (r_vcnt < c_V_VIS);
    assign w_hsync  = !((r_hcnt >= c_HS_BEG) && (r_hcnt <= c_HS_END));
    assign w_vsync  = !((r_vcnt >= c_VS_BEG) && (r_vcnt <= c_VS_END));

    always_comb begin
        w_pixel = 8'h00;
        if (w_active) begin
            if (vga.pattern_sel) begin
                w_pixel = f_bar_colour(w_bar_idx);
            end else begin
                w_pixel = r_hcnt[7:0] ^ w_xor_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel <= 8'h00;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_pixel <= w_pixel;
            r_hsync <= w_hsync;
            r_vsync <= w_vsync;
        end
    end

    assign vga.pixel = r_pixel;
    assign vga.hsync = r_hsync;
    assign vga.vsync = r_vsync;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Scoreboard bench: full-size instance A plus a shrunken
//               instance B so whole-frame timing fits in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pattern_gen;

    typedef struct {
        bit         in_rst;
        int         n;
        logic [7:0] px;
        logic       hs;
        logic       vs;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   edges;
    int   checks;
    int   passed;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] bar_col [8];

    vga_pattern_gen_if if_a();
    vga_pattern_gen_if if_b();

    vga_pattern_gen u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_a)
    );

    vga_pattern_gen #(
        .H_VISIBLE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_VISIBLE (12), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges seen since reset release; output index n = edges-1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic push_a(input bit r, input int n, input logic [7:0] px,
                          input logic hs, input logic vs, input string tag);
        exp_t e;
        e.in_rst = r; e.n = n; e.px = px; e.hs = hs; e.vs = vs; e.tag = tag;
        q_a.push_back(e);
    endtask

    task automatic push_b(input bit r, input int n, input logic [7:0] px,
                          input logic hs, input logic vs, input string tag);
        exp_t e;
        e.in_rst = r; e.n = n; e.px = px; e.hs = hs; e.vs = vs; e.tag = tag;
        q_b.push_back(e);
    endtask

    task automatic compare(input exp_t e, input logic [7:0] px,
                           input logic hs, input logic vs);
        checks++;
        if (px === e.px && hs === e.hs && vs === e.vs) begin
            passed++;
        end else begin
            $display("FAIL %s n=%0d: got px=%h hs=%b vs=%b, want px=%h hs=%b vs=%b",
                     e.tag, e.n, px, hs, vs, e.px, e.hs, e.vs);
        end
    endtask

    task automatic missed(input exp_t e);
        checks++;
        $display("FAIL %s n=%0d: never sampled, want px=%h hs=%b vs=%b",
                 e.tag, e.n, e.px, e.hs, e.vs);
    endtask

    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            if (!rst_n && q_a[0].in_rst) begin
                compare(q_a.pop_front(), if_a.pixel, if_a.hsync, if_a.vsync);
            end else if (rst_n && !q_a[0].in_rst) begin
                while (q_a.size() > 0 && !q_a[0].in_rst && q_a[0].n < edges - 1)
                    missed(q_a.pop_front());
                if (q_a.size() > 0 && !q_a[0].in_rst && q_a[0].n == edges - 1)
                    compare(q_a.pop_front(), if_a.pixel, if_a.hsync, if_a.vsync);
            end
        end
    end

    always @(negedge clk) begin
        if (q_b.size() > 0) begin
            if (!rst_n && q_b[0].in_rst) begin
                compare(q_b.pop_front(), if_b.pixel, if_b.hsync, if_b.vsync);
            end else if (rst_n && !q_b[0].in_rst) begin
                while (q_b.size() > 0 && !q_b[0].in_rst && q_b[0].n < edges - 1)
                    missed(q_b.pop_front());
                if (q_b.size() > 0 && !q_b[0].in_rst && q_b[0].n == edges - 1)
                    compare(q_b.pop_front(), if_b.pixel, if_b.hsync, if_b.vsync);
            end
        end
    end

    initial begin
        bar_col[0] = 8'hFF; bar_col[1] = 8'hFC; bar_col[2] = 8'h1F; bar_col[3] = 8'h1C;
        bar_col[4] = 8'hE3; bar_col[5] = 8'hE0; bar_col[6] = 8'h03; bar_col[7] = 8'h00;
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        if_a.pattern_sel = 1'b1;
        if_b.pattern_sel = 1'b0;

        for (int i = 0; i < 10; i++) begin
            push_a(1, 0, 8'h00, 1'b1, 1'b1, "a_reset_hold");
            push_b(1, 0, 8'h00, 1'b1, 1'b1, "b_reset_hold");
        end

        // Instance A: colour bars on line 0, line timing, then XOR
        for (int b = 0; b < 8; b++) begin
            push_a(0, b * 90,      bar_col[b], 1'b1, 1'b1, "a_bar_first");
            push_a(0, b * 90 + 89, bar_col[b], 1'b1, 1'b1, "a_bar_last");
        end
        push_a(0, 720,        8'h00, 1'b1, 1'b1, "a_blank_720");
        push_a(0, 755,        8'h00, 1'b1, 1'b1, "a_hs_pre");
        push_a(0, 756,        8'h00, 1'b0, 1'b1, "a_hs_fall");
        push_a(0, 827,        8'h00, 1'b0, 1'b1, "a_hs_last");
        push_a(0, 828,        8'h00, 1'b1, 1'b1, "a_hs_rise");
        push_a(0, 935,        8'h00, 1'b1, 1'b1, "a_blank_935");
        push_a(0, 936,        8'hFF, 1'b1, 1'b1, "a_line1_col0");
        push_a(0, 936 + 756,  8'h00, 1'b0, 1'b1, "a_line1_hs");
        push_a(0, 3 * 936 + 199, 8'h1F, 1'b1, 1'b1, "a_sel_old");
        push_a(0, 3 * 936 + 200, 8'hCB, 1'b1, 1'b1, "a_sel_new");
        push_a(0, 5 * 936 + 3,   8'h06, 1'b1, 1'b1, "a_xor_l5c3");
        push_a(0, 7 * 936 + 700, 8'hBB, 1'b1, 1'b1, "a_xor_l7c700");
        push_a(0, 7 * 936 + 720, 8'h00, 1'b1, 1'b1, "a_xor_blank");
        push_a(0, 8 * 936 + 100, 8'h6C, 1'b1, 1'b1, "a_pre_reset");

        // Instance B: 24 clocks/line, 17 lines/frame, hsync low 18..20, vsync low lines 13..14
        push_b(0, 5,   8'h05, 1'b1, 1'b1, "b_xor_l0c5");
        push_b(0, 17,  8'h00, 1'b1, 1'b1, "b_hs_pre");
        push_b(0, 18,  8'h00, 1'b0, 1'b1, "b_hs_fall");
        push_b(0, 20,  8'h00, 1'b0, 1'b1, "b_hs_last");
        push_b(0, 21,  8'h00, 1'b1, 1'b1, "b_hs_rise");
        push_b(0, 279, 8'h04, 1'b1, 1'b1, "b_last_active");
        push_b(0, 280, 8'h00, 1'b1, 1'b1, "b_h_blank");
        push_b(0, 288, 8'h00, 1'b1, 1'b1, "b_v_blank");
        push_b(0, 312, 8'h00, 1'b1, 1'b0, "b_vs_fall");
        push_b(0, 359, 8'h00, 1'b1, 1'b0, "b_vs_last");
        push_b(0, 360, 8'h00, 1'b1, 1'b1, "b_vs_rise");
        push_b(0, 408, 8'h00, 1'b1, 1'b1, "b_frame_wrap");
        push_b(0, 437, 8'h04, 1'b1, 1'b1, "b_f1_l1c5");

        repeat (10) @(negedge clk);
        #2 rst_n = 1'b1;

        while (edges != 3 * 936 + 200) @(negedge clk);
        if_a.pattern_sel = 1'b0;

        while (edges != 8 * 936 + 101) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            push_a(1, 0, 8'h00, 1'b1, 1'b1, "a_mid_reset");
            push_b(1, 0, 8'h00, 1'b1, 1'b1, "b_mid_reset");
        end
        @(posedge clk);
        #2 rst_n = 1'b0;

        push_a(0, 0,   8'h00, 1'b1, 1'b1, "a_restart_c0");
        push_a(0, 3,   8'h03, 1'b1, 1'b1, "a_restart_c3");
        push_a(0, 755, 8'h00, 1'b1, 1'b1, "a_restart_hs_pre");
        push_a(0, 756, 8'h00, 1'b0, 1'b1, "a_restart_hs_fall");
        push_b(0, 0,   8'h00, 1'b1, 1'b1, "b_restart_c0");
        push_b(0, 5,   8'h05, 1'b1, 1'b1, "b_restart_c5");
        push_b(0, 18,  8'h00, 1'b0, 1'b1, "b_restart_hs");

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        while (edges < 800) @(negedge clk);
        repeat (2) @(negedge clk);

        while (q_a.size() > 0) missed(q_a.pop_front());
        while (q_b.size() > 0) missed(q_b.pop_front());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
